// File: rtl/multistage_caesar_pipe.sv
// Streaming N-stage Caesar cipher: one programmable key and one pipeline register per stage.
// Optional macro CAESAR_PASSTHRU_NONLETTER_EN: non-letters pass through unchanged instead of being flagged.
module multistage_caesar_pipe #(
  parameter int NUM_STAGES  = 3,
  parameter int IDX_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  parameter int RESET_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_char,
  input  logic             in_decrypt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_char,
  output logic             out_decrypt,
  output logic             out_err_char,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_idx,
  input  logic [4:0]       key_wr_shift,
  input  logic             key_wr_dir,
  output logic             key_wr_ack,
  output logic             key_wr_err,
  output logic             busy
);

  localparam int unsigned LAST = NUM_STAGES - 1;

`ifdef CAESAR_PASSTHRU_NONLETTER_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  logic [NUM_STAGES-1:0] r_vld;
  logic [7:0]            r_char [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_dec;
  logic [NUM_STAGES-1:0] r_let;
  logic [NUM_STAGES-1:0] r_up;
  logic                  r_err;
  logic [4:0]            r_key_shift [NUM_STAGES];
  logic [NUM_STAGES-1:0] r_key_dir;
  logic                  r_wr_ack;
  logic                  r_wr_err;

  logic                  w_adv;
  logic                  w_in_fire;
  logic                  w_busy;
  logic                  w_idx_ok;
  logic                  w_wr_ok;
  logic                  w_in_up;
  logic                  w_in_lo;
  logic [NUM_STAGES-1:0] w_src_vld;
  logic [NUM_STAGES-1:0] w_src_dec;
  logic [NUM_STAGES-1:0] w_src_let;
  logic [NUM_STAGES-1:0] w_src_up;
  logic [7:0]            w_res [NUM_STAGES];

  // Offset arithmetic within one case; k is always <= 25 so one correction suffices.
  function automatic logic [7:0] f_shift(input logic [7:0] c, input logic up,
                                         input logic [4:0] k, input logic dir);
    logic [7:0]        v_base;
    logic [5:0]        v_o;
    logic [5:0]        v_t;
    logic signed [5:0] v_d;
    v_base = up ? 8'h41 : 8'h61;
    v_o    = 6'(c - v_base);
    if (!dir) begin
      v_t = v_o + {1'b0, k};
      if (v_t >= 6'd26) v_t = v_t - 6'd26;
    end else begin
      v_d = $signed(v_o) - $signed({1'b0, k});
      if (v_d < 0) v_d = v_d + 6'sd26;
      v_t = $unsigned(v_d);
    end
    return v_base + {2'b00, v_t};
  endfunction

  assign w_adv     = !r_vld[LAST] || out_ready;
  assign w_in_fire = in_valid && w_adv;
  assign w_busy    = |r_vld;
  assign w_idx_ok  = int'(key_wr_idx) < NUM_STAGES;
  assign w_wr_ok   = key_wr_en && !w_busy && !w_in_fire && w_idx_ok && (key_wr_shift <= 5'd25);
  assign w_in_up   = (in_char >= 8'h41) && (in_char <= 8'h5A);
  assign w_in_lo   = (in_char >= 8'h61) && (in_char <= 8'h7A);

  // Decrypt walks the key list backwards with each direction inverted, undoing encrypt.
  always_comb begin
    logic [7:0]  v_c;
    int unsigned v_ki;
    w_src_vld = '0;
    w_src_dec = '0;
    w_src_let = '0;
    w_src_up  = '0;
    v_c       = '0;
    v_ki      = 0;
    for (int unsigned s = 0; s < NUM_STAGES; s++) begin
      if (s == 0) begin
        w_src_vld[s] = in_valid;
        w_src_dec[s] = in_decrypt;
        w_src_let[s] = w_in_up || w_in_lo;
        w_src_up[s]  = w_in_up;
        v_c          = in_char;
      end else begin
        w_src_vld[s] = r_vld[s-1];
        w_src_dec[s] = r_dec[s-1];
        w_src_let[s] = r_let[s-1];
        w_src_up[s]  = r_up[s-1];
        v_c          = r_char[s-1];
      end
      v_ki     = w_src_dec[s] ? (LAST - s) : s;
      w_res[s] = w_src_let[s]
               ? f_shift(v_c, w_src_up[s], r_key_shift[v_ki], r_key_dir[v_ki] ^ w_src_dec[s])
               : v_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_dec     <= '0;
      r_let     <= '0;
      r_up      <= '0;
      r_err     <= 1'b0;
      r_key_dir <= '0;
      r_wr_ack  <= 1'b0;
      r_wr_err  <= 1'b0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        r_char[s]      <= '0;
        r_key_shift[s] <= 5'(RESET_SHIFT);
      end
    end else begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= key_wr_en && !w_wr_ok;
      for (int unsigned s = 0; s < NUM_STAGES; s++) begin
        if (w_wr_ok && (key_wr_idx == IDX_W'(s))) begin
          r_key_shift[s] <= key_wr_shift;
          r_key_dir[s]   <= key_wr_dir;
        end
      end
      if (w_adv) begin
        for (int unsigned s = 0; s < NUM_STAGES; s++) begin
          r_vld[s]  <= w_src_vld[s];
          r_dec[s]  <= w_src_dec[s];
          r_let[s]  <= w_src_let[s];
          r_up[s]   <= w_src_up[s];
          r_char[s] <= (s == LAST && !w_src_let[s] && !PASSTHRU) ? 8'h00 : w_res[s];
        end
        r_err <= w_src_vld[LAST] && !w_src_let[LAST] && !PASSTHRU;
      end
    end
  end

  assign in_ready     = w_adv;
  assign out_valid    = r_vld[LAST];
  assign out_char     = r_char[LAST];
  assign out_decrypt  = r_dec[LAST];
  assign out_err_char = r_err;
  assign key_wr_ack   = r_wr_ack;
  assign key_wr_err   = r_wr_err;
  assign busy         = w_busy;

endmodule

// File: tb/tb_multistage_caesar_pipe.sv
// Directed bench for multistage_caesar_pipe (3 stages) with hand-computed expected characters.
module tb_multistage_caesar_pipe;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       in_decrypt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_decrypt;
  logic       out_err_char;
  logic       key_wr_en;
  logic [1:0] key_wr_idx;
  logic [4:0] key_wr_shift;
  logic       key_wr_dir;
  logic       key_wr_ack;
  logic       key_wr_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  multistage_caesar_pipe #(.NUM_STAGES(3), .RESET_SHIFT(0)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
    .out_decrypt(out_decrypt), .out_err_char(out_err_char),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_shift(key_wr_shift),
    .key_wr_dir(key_wr_dir), .key_wr_ack(key_wr_ack), .key_wr_err(key_wr_err),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic key_wr(input logic [1:0] idx, input logic [4:0] sh, input logic dir,
                        input logic exp_ack, input string tag);
    @(negedge clk);
    key_wr_en = 1'b1; key_wr_idx = idx; key_wr_shift = sh; key_wr_dir = dir;
    @(negedge clk);
    key_wr_en = 1'b0;
    #1;
    chk({tag, "_ack"}, 32'(key_wr_ack), 32'(exp_ack));
    chk({tag, "_err"}, 32'(key_wr_err), 32'(!exp_ack));
  endtask

  // Streams txs through the block; out_ready is held low for the first stall_len cycles.
  task automatic stream(input string txs, input string exps, input logic [15:0] dec_mask,
                        input logic [15:0] err_mask, input int stall_len, input string tag);
    int n, sent, got, cyc, acc_stall;
    logic [7:0] e;
    n = txs.len(); sent = 0; got = 0; cyc = 0; acc_stall = 0;
    while (got < n && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc >= stall_len);
      in_valid  = (sent < n);
      if (sent < n) begin
        in_char    = txs[sent];
        in_decrypt = dec_mask[sent];
      end
      #1;
      if (cyc >= 3 && cyc < stall_len) begin
        chk($sformatf("%s_inrdy_low%0d", tag, cyc), 32'(in_ready), 32'd0);
        e = err_mask[got] ? 8'h00 : exps[got];
        chk($sformatf("%s_hold%0d", tag, cyc), 32'(out_char), 32'(e));
      end
      if (out_valid && out_ready) begin
        e = err_mask[got] ? 8'h00 : exps[got];
        chk($sformatf("%s_c%0d", tag, got), 32'(out_char), 32'(e));
        chk($sformatf("%s_d%0d", tag, got), 32'(out_decrypt), 32'(dec_mask[got]));
        chk($sformatf("%s_e%0d", tag, got), 32'(out_err_char), 32'(err_mask[got]));
        got++;
      end
      if (in_valid && in_ready) begin
        sent++;
        if (cyc < stall_len) acc_stall++;
      end
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_count"}, 32'(got), 32'(n));
    if (stall_len > 0) chk({tag, "_acc_stall"}, 32'(acc_stall), 32'd3);
    else chk({tag, "_cycles"}, 32'(cyc), 32'(n + 3));
  endtask

  task automatic wait_out(input logic [7:0] exp, input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk({tag, "_char"}, 32'(out_char), 32'(exp));
  endtask

  initial begin
    logic [15:0] nl_err;
    string       nl_exp;
`ifdef CAESAR_PASSTHRU_NONLETTER_EN
    nl_err = 16'h0000;
`else
    nl_err = 16'h0002;
`endif
    nl_exp = "g5H";

    rst = 1'b1; in_valid = 1'b0; in_char = 8'h00; in_decrypt = 1'b0; out_ready = 1'b1;
    key_wr_en = 1'b0; key_wr_idx = '0; key_wr_shift = '0; key_wr_dir = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'h00);
    chk("rst_out_dec", 32'(out_decrypt), 32'd0);
    chk("rst_out_err", 32'(out_err_char), 32'd0);
    chk("rst_ack", 32'(key_wr_ack), 32'd0);
    chk("rst_wr_err", 32'(key_wr_err), 32'd0);
    rst = 1'b0;

    // Keys (3,R) (5,L) (10,R): net +8
    key_wr(2'd0, 5'd3, 1'b0, 1'b1, "wr_k0");
    key_wr(2'd1, 5'd5, 1'b1, 1'b1, "wr_k1");
    key_wr(2'd2, 5'd10, 1'b0, 1'b1, "wr_k2");

    // Latency: 'A' -> 'I' three cycles after the handshake
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h41; in_decrypt = 1'b0;
    #1 chk("lat_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1 chk("lat_c3", 32'(out_valid), 32'd1);
    chk("lat_char", 32'(out_char), 32'h49);

    stream("z", "h", 16'h0000, 16'h0000, 0, "enc_z");
    stream("Ih", "Az", 16'h0003, 16'h0000, 0, "dec_Ih");
    stream("HeLLoPmTTw", "PmTTwHeLLo", 16'h03E0, 16'h0000, 0, "round");
    stream("ABCDEF", "IJKLMN", 16'h0000, 16'h0000, 5, "stall");

    // Write while a character is in flight is rejected; output uses the old key
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h41; in_decrypt = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 2'd0; key_wr_shift = 5'd1; key_wr_dir = 1'b0;
    #1 chk("busy_flag", 32'(busy), 32'd1);
    @(negedge clk);
    key_wr_en = 1'b0;
    #1 chk("busywr_err", 32'(key_wr_err), 32'd1);
    chk("busywr_ack", 32'(key_wr_ack), 32'd0);
    wait_out(8'h49, "busywr_out");

    // Write coinciding with an input handshake: input wins, write rejected
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h41; in_decrypt = 1'b0;
    key_wr_en = 1'b1; key_wr_idx = 2'd1; key_wr_shift = 5'd7; key_wr_dir = 1'b1;
    #1 chk("coll_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; key_wr_en = 1'b0;
    #1 chk("coll_err", 32'(key_wr_err), 32'd1);
    chk("coll_ack", 32'(key_wr_ack), 32'd0);
    wait_out(8'h49, "coll_out");

    key_wr(2'd0, 5'd26, 1'b0, 1'b0, "wr_sh26");
    key_wr(2'd3, 5'd7, 1'b1, 1'b0, "wr_idx3");
    key_wr(2'd1, 5'd7, 1'b1, 1'b1, "wr_k1_new");
    @(negedge clk);
    #1 chk("ack_pulse_end", 32'(key_wr_ack), 32'd0);

    // Keys (3,R) (7,L) (10,R): net +6
    stream("Az", "Gf", 16'h0000, 16'h0000, 0, "newkey");
    stream("a5B", nl_exp, 16'h0000, nl_err, 0, "nonlet");
    stream("@[`{Zz", "@[`{Ff", 16'h0000,
`ifdef CAESAR_PASSTHRU_NONLETTER_EN
           16'h0000,
`else
           16'h000F,
`endif
           0, "bound");

    // Reset with two characters in flight
    @(negedge clk);
    in_valid = 1'b1; in_char = 8'h41;
    @(negedge clk);
    in_char = 8'h42;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_char", 32'(out_char), 32'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("mrst_stale%0d", k), 32'(out_valid), 32'd0);
    end
    stream("Az", "Az", 16'h0000, 16'h0000, 0, "rstkey");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multistage_caesar_pipe.md
Name: multistage_caesar_pipe

Overview:
- Streaming N-stage Caesar cipher. Successor to the fixed 3-stage combinational/registered cipher.
- Each stage applies one programmable shift/direction key. Stages are pipelined one register per stage.
- Valid/ready handshake with backpressure on both sides.
- Per-character encrypt/decrypt mode travels with the data. Sits between the character source and the ciphertext sink.

Parameters:
- NUM_STAGES, 3, number of cipher stages and pipeline registers (>=1).
- IDX_W, $clog2(NUM_STAGES) (min 1), width of the key index.
- RESET_SHIFT, 0, shift value loaded into every key on reset (0..25).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input character valid
- in_ready  out  1  block can accept the input character this cycle
- in_char  in  8  ASCII input character
- in_decrypt  in  1  0 = encrypt, 1 = decrypt
- out_valid  out  1  output character valid
- out_ready  in  1  sink accepts the output this cycle
- out_char  out  8  result character
- out_decrypt  out  1  mode that travelled with out_char
- out_err_char  out  1  input was not a letter
- key_wr_en  in  1  key write strobe
- key_wr_idx  in  IDX_W  stage index to write
- key_wr_shift  in  5  shift amount
- key_wr_dir  in  1  0 = right (+), 1 = left (-)
- key_wr_ack  out  1  one-cycle pulse: write accepted
- key_wr_err  out  1  one-cycle pulse: write rejected
- busy  out  1  any pipeline stage holds valid data

Behaviour:
- Reset (rst=1 at posedge): all stage valids = 0, so out_valid = 0 and busy = 0.
  - out_char = 0x00, out_decrypt = 0, out_err_char = 0.
  - key_wr_ack = 0, key_wr_err = 0.
  - Every key resets to shift = RESET_SHIFT, dir = 0.
  - Reset mid-stream drops all in-flight characters; nothing is output after reset.
- Pipeline advance: adv = !stage_valid[NUM_STAGES-1] || out_ready.
  - in_ready = adv.
  - When adv is high, all stages shift by one; stage 0 loads in_valid and its data.
  - When adv is low, all stages hold.
- Latency and throughput: NUM_STAGES cycles from input handshake to out_valid when unstalled. Throughput is 1 char/cycle. No bubble insertion and no reordering.
- Output hold: out_* are the registered last-stage contents. They hold stable while out_valid && !out_ready.
- Character classification at stage 0:
  - Upper case: 0x41..0x5A, base 0x41.
  - Lower case: 0x61..0x7A, base 0x61.
  - Anything else is a non-letter. The class flag travels with the data.
- Stage s arithmetic (letters only), with offset o = char - base (0..25) and shift k:
  - Right: o' = o + k; if o' >= 26, subtract 26.
  - Left: o' = o - k, computed in 6-bit signed; if negative, add 26.
  - Result = base + o'. Case is always preserved.
- Stage s key selection:
  - Encrypt uses key[s] as programmed.
  - Decrypt uses key[NUM_STAGES-1-s] with its direction inverted.
  - Therefore decrypt(encrypt(c)) = c for any key set.
- Key writes:
  - Accepted only when busy = 0, no input handshake occurs in the same cycle, key_wr_idx < NUM_STAGES, and key_wr_shift <= 25.
  - Accepted: key updates at that edge and key_wr_ack pulses the next cycle.
  - Rejected: key is unchanged and key_wr_err pulses the next cycle.
  - Keys are therefore never changed while characters are in flight.
- Key write and input handshake in the same cycle: the write is rejected and the input is accepted.
- busy = OR of all stage valids.

Optional Feature:
- Macro: CAESAR_PASSTHRU_NONLETTER_EN.
- Defined: a non-letter passes through all stages unchanged; out_err_char = 0.
- Undefined: a non-letter gives out_char = 0x00 and out_err_char = 1. It still occupies its pipeline slot and still produces out_valid, so ordering is kept.

Test Plan:
1. Keys are (3,R), (5,L), (10,R) (net +8); NUM_STAGES = 3; send 'A' encrypt, out_ready = 1 -> out_char 0x49 'I' exactly 3 cycles after the handshake; then 'z' -> 'h' (0x68), case preserved.
2. Same keys; decrypt 'I' and 'h' -> 'A' and 'z', out_decrypt = 1; a back-to-back stream "HeLLo" encrypt then decrypt -> round trip is identical, 1 char/cycle.
3. Stream 6 chars with out_ready = 0 held for 5 cycles -> in_ready drops once the last stage is full (after 3 accepted); out_char holds stable; after release all 6 appear in order, none lost or duplicated.
4. Key writes:
   - while busy = 1 -> key_wr_err pulses and the subsequent output reflects the old key;
   - shift 26 or idx 3 when idle -> key_wr_err;
   - (7,L) at idx 1 when idle -> key_wr_ack and the new key takes effect.
5. Send '5' (0x35) -> with macro: 0x35 and err = 0; without macro: 0x00 and err = 1; neighbouring letters are unaffected.
6. Assert rst with 2 chars in flight -> out_valid = 0 next cycle, busy = 0, keys return to RESET_SHIFT/right, no stale output afterwards.
